av2_intra_pred_sched: RTL and testbench

Sequencer for the intra prediction engine. Accepts one coding-block command and splits it into transform-sized sub-blocks in raster order. For each sub-block it requests neighbour reference samples, pulses start to the predictor, then forwards the predictor's valid/ready handshake to reconstruction. It sits between the block-level decode control and av2_intra_prediction / the reference sample buffer.

---
 rtl/av2_intra_pkg.sv | 37 +++
 rtl/av2_tb_walker.sv | 62 ++++++
 rtl/av2_intra_pred_sched.sv | 175 +++++++++++++++++
 tb/tb_av2_intra_pred_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/av2_intra_pkg.sv
// Shared types and helpers for the intra prediction sub-block scheduler.
// Holds the FSM encoding, the block-edge log2 limits and small log2 arithmetic helpers.
package av2_intra_pkg;

  localparam logic [2:0] LOG2_MIN = 3'd2;
  localparam logic [2:0] LOG2_MAX = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_PRED = 3'd3,
    ST_NEXT      = 3'd4
  } sched_state_e;

  function automatic logic [2:0] clamp_log2(input logic [2:0] v, input logic [2:0] hi);
    logic [2:0] r;
    if (v < LOG2_MIN) begin
      r = LOG2_MIN;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [2:0] min_log2(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  // Seven bits so that an edge of 64 is representable.
  function automatic logic [6:0] pow2(input logic [2:0] l);
    return 7'd1 << l;
  endfunction

endpackage

// File: rtl/av2_tb_walker.sv
// Raster walker over transform sub-blocks of one coding block.
// Owns the x/y offsets, the advance step and the last-sub-block flag.
module av2_tb_walker
  import av2_intra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       advance_i,
  input  logic [2:0] bw_log2_i,
  input  logic [2:0] bh_log2_i,
  input  logic [2:0] tw_log2_i,
  input  logic [2:0] th_log2_i,
  output logic [5:0] x_o,
  output logic [5:0] y_o,
  output logic       last_o
);

  logic [6:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [6:0] x_step;

  assign x_step = x_q + pow2(tw_log2_i);

  // Next offset: restart at the origin, step right, or wrap to the next row.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (init_i) begin
      x_d = 7'd0;
      y_d = 7'd0;
    end else if (advance_i) begin
      if (x_step == pow2(bw_log2_i)) begin
        x_d = 7'd0;
        y_d = y_q + pow2(th_log2_i);
      end else begin
        x_d = x_step;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Offset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 7'd0;
      y_q <= 7'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q[5:0];
  assign y_o    = y_q[5:0];
  assign last_o = (x_q == pow2(bw_log2_i) - pow2(tw_log2_i)) &&
                  (y_q == pow2(bh_log2_i) - pow2(th_log2_i));

endmodule

// File: rtl/av2_intra_pred_sched.sv
// Intra prediction scheduler: splits one block command into transform sub-blocks,
// fetches references, starts the predictor and relays its handshake to reconstruction.
module av2_intra_pred_sched
  import av2_intra_pkg::*;
#(
  parameter int MAX_LOG2       = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic [2:0] blk_w_log2,
  input  logic [2:0] blk_h_log2,
  input  logic [2:0] tx_w_log2,
  input  logic [2:0] tx_h_log2,
  input  logic [6:0] blk_mode,
  output logic       ref_req,
  output logic [5:0] ref_x,
  output logic [5:0] ref_y,
  input  logic       ref_done,
  output logic       pred_start,
  output logic [6:0] pred_mode,
  output logic [5:0] pred_w,
  output logic [5:0] pred_h,
  input  logic       pred_valid,
  output logic       pred_ready,
  output logic       tb_valid,
  input  logic       recon_ready,
  output logic       tb_last,
  output logic       blk_done,
  output logic       err_timeout
);

  localparam logic [2:0]      MAX_L   = 3'(MAX_LOG2);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  sched_state_e    state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic [2:0]      bw_q, bw_d, bh_q, bh_d, tw_q, tw_d, th_q, th_d;
  logic [6:0]      mode_q, mode_d;
  logic [5:0]      pw_q, pw_d, ph_q, ph_d;
  logic [2:0]      bw_c, bh_c, tw_c, th_c;
  logic            accept, advance, last_s;

  assign bw_c = clamp_log2(blk_w_log2, MAX_L);
  assign bh_c = clamp_log2(blk_h_log2, MAX_L);
  assign tw_c = min_log2(tx_w_log2, bw_c);
  assign th_c = min_log2(tx_h_log2, bh_c);

  // Next-state, watchdog and command-latch logic.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    bw_d    = bw_q;
    bh_d    = bh_q;
    tw_d    = tw_q;
    th_d    = th_q;
    mode_d  = mode_q;
    pw_d    = pw_q;
    ph_d    = ph_q;
    accept  = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          bw_d    = bw_c;
          bh_d    = bh_c;
          tw_d    = tw_c;
          th_d    = th_c;
          mode_d  = blk_mode;
          pw_d    = 6'(pow2(tw_c) - 7'd1);
          ph_d    = 6'(pow2(th_c) - 7'd1);
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (ref_done) begin
          state_d = ST_START;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_START: begin
        wd_d    = {TO_W{1'b0}};
        state_d = ST_WAIT_PRED;
      end
      ST_WAIT_PRED: begin
        // A handshake on the final watchdog cycle still wins over the timeout.
        if (pred_valid && recon_ready) begin
          state_d = ST_NEXT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d    = wd_q + {{(TO_W-1){1'b0}}, 1'b1};
          state_d = ST_WAIT_PRED;
        end
      end
      ST_NEXT: begin
        advance = 1'b1;
        if (last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, watchdog and latched command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wd_q    <= {TO_W{1'b0}};
      err_q   <= 1'b0;
      bw_q    <= 3'd0;
      bh_q    <= 3'd0;
      tw_q    <= 3'd0;
      th_q    <= 3'd0;
      mode_q  <= 7'd0;
      pw_q    <= 6'd0;
      ph_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      bw_q    <= bw_d;
      bh_q    <= bh_d;
      tw_q    <= tw_d;
      th_q    <= th_d;
      mode_q  <= mode_d;
      pw_q    <= pw_d;
      ph_q    <= ph_d;
    end
  end

  av2_tb_walker u_walker (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_i    (accept),
    .advance_i (advance),
    .bw_log2_i (bw_q),
    .bh_log2_i (bh_q),
    .tw_log2_i (tw_q),
    .th_log2_i (th_q),
    .x_o       (ref_x),
    .y_o       (ref_y),
    .last_o    (last_s)
  );

  assign blk_ready   = (state_q == ST_IDLE);
  assign ref_req     = (state_q == ST_FETCH);
  assign pred_start  = (state_q == ST_START);
  assign pred_ready  = (state_q == ST_WAIT_PRED) && recon_ready;
  assign tb_valid    = (state_q == ST_WAIT_PRED) && pred_valid;
  assign blk_done    = (state_q == ST_NEXT) && last_s;
  // Walker offsets are stale while idle, so the flag is masked there.
  assign tb_last     = (state_q != ST_IDLE) && last_s;
  assign pred_mode   = mode_q;
  assign pred_w      = pw_q;
  assign pred_h      = ph_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_av2_intra_pred_sched.sv
// Self-checking bench for av2_intra_pred_sched: sub-block index model plus directed literal checks.
module tb_av2_intra_pred_sched;

  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blk_valid, blk_ready;
  logic [2:0] blk_w_log2, blk_h_log2, tx_w_log2, tx_h_log2;
  logic [6:0] blk_mode, pred_mode;
  logic       ref_req, ref_done, pred_start, pred_valid, pred_ready;
  logic [5:0] ref_x, ref_y, pred_w, pred_h;
  logic       tb_valid, recon_ready, tb_last, blk_done, err_timeout;

  always #5 clk = ~clk;

  av2_intra_pred_sched dut (
    .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_w_log2(blk_w_log2), .blk_h_log2(blk_h_log2), .tx_w_log2(tx_w_log2),
    .tx_h_log2(tx_h_log2), .blk_mode(blk_mode), .ref_req(ref_req), .ref_x(ref_x),
    .ref_y(ref_y), .ref_done(ref_done), .pred_start(pred_start), .pred_mode(pred_mode),
    .pred_w(pred_w), .pred_h(pred_h), .pred_valid(pred_valid), .pred_ready(pred_ready),
    .tb_valid(tb_valid), .recon_ready(recon_ready), .tb_last(tb_last),
    .blk_done(blk_done), .err_timeout(err_timeout)
  );

  int tests = 0;
  int fails = 0;

  // Model: phase 0 idle, 1 fetch, 2 start, 3 wait, 4 next; sub-block index k in raster order.
  int m_st, m_k, m_total, m_cols, m_sw, m_sh, m_pw, m_ph, m_mode, m_err, m_wait;
  int p_ref = 100, p_pv = 100, p_rr = 100;
  int n_start, n_done;
  int q_x[$], q_y[$], q_last[$];

  function automatic int clampl(int v);
    return (v < 2) ? 2 : ((v > 6) ? 6 : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_k = 0; m_total = 1; m_cols = 1; m_sw = 1; m_sh = 1;
    m_pw = 0; m_ph = 0; m_mode = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_accept();
    int bwl, bhl, twl, thl;
    bwl = clampl(int'(blk_w_log2));
    bhl = clampl(int'(blk_h_log2));
    twl = (int'(tx_w_log2) < bwl) ? int'(tx_w_log2) : bwl;
    thl = (int'(tx_h_log2) < bhl) ? int'(tx_h_log2) : bhl;
    m_sw = 1 << twl;
    m_sh = 1 << thl;
    m_cols = (1 << bwl) / m_sw;
    m_total = m_cols * ((1 << bhl) / m_sh);
    m_k = 0;
    m_pw = m_sw - 1;
    m_ph = m_sh - 1;
    m_mode = int'(blk_mode);
  endtask

  task automatic model_step();
    case (m_st)
      0: if (blk_valid) begin model_accept(); m_err = 0; m_st = 1; end
      1: if (ref_done) m_st = 2;
      2: begin m_st = 3; m_wait = 0; end
      3: begin
        if (pred_valid && recon_ready) m_st = 4;
        else begin
          m_wait++;
          if (m_wait >= TIMEOUT) begin m_err = 1; m_st = 0; end
        end
      end
      4: if (m_k == m_total - 1) m_st = 0; else begin m_k++; m_st = 1; end
      default: m_st = 0;
    endcase
  endtask

  task automatic model_compare();
    int is_last;
    is_last = (m_k == m_total - 1) ? 1 : 0;
    chk("blk_ready", int'(blk_ready), (m_st == 0) ? 1 : 0);
    chk("ref_req", int'(ref_req), (m_st == 1) ? 1 : 0);
    chk("pred_start", int'(pred_start), (m_st == 2) ? 1 : 0);
    chk("pred_ready", int'(pred_ready), (m_st == 3 && recon_ready) ? 1 : 0);
    chk("tb_valid", int'(tb_valid), (m_st == 3 && pred_valid) ? 1 : 0);
    chk("blk_done", int'(blk_done), (m_st == 4 && is_last == 1) ? 1 : 0);
    chk("tb_last", int'(tb_last), (m_st != 0 && is_last == 1) ? 1 : 0);
    chk("err_timeout", int'(err_timeout), m_err);
    chk("pred_w", int'(pred_w), m_pw);
    chk("pred_h", int'(pred_h), m_ph);
    chk("pred_mode", int'(pred_mode), m_mode);
    if (m_st != 0) begin
      chk("ref_x", int'(ref_x), (m_k % m_cols) * m_sw);
      chk("ref_y", int'(ref_y), (m_k / m_cols) * m_sh);
    end
    if (pred_start) begin
      n_start++;
      q_x.push_back(int'(ref_x));
      q_y.push_back(int'(ref_y));
      q_last.push_back(int'(tb_last));
    end
    if (blk_done) n_done++;
  endtask

  // Entered at a falling edge; leaves at the next falling edge.
  task automatic cycle();
    ref_done    = ($urandom_range(99) < p_ref);
    pred_valid  = ($urandom_range(99) < p_pv);
    recon_ready = ($urandom_range(99) < p_rr);
    #1;
    model_compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_log();
    n_start = 0; n_done = 0;
    q_x.delete(); q_y.delete(); q_last.delete();
  endtask

  task automatic issue(input int bw, input int bh, input int tw, input int th, input int mode);
    blk_valid  = 1'b1;
    blk_w_log2 = 3'(bw); blk_h_log2 = 3'(bh);
    tx_w_log2  = 3'(tw); tx_h_log2  = 3'(th);
    blk_mode   = 7'(mode);
    cycle();
    blk_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (m_st != 0 && n < budget) begin cycle(); n++; end
    if (m_st != 0) begin
      tests++; fails++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    blk_valid = 1'b0;
    model_reset();
    #1;
    model_compare();
    chk("rst_ref_x", int'(ref_x), 0);
    chk("rst_ref_y", int'(ref_y), 0);
    chk("rst_blk_ready", int'(blk_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_x[4] = '{0, 8, 0, 8};
    int exp_y[4] = '{0, 0, 8, 8};
    int exp_l[4] = '{0, 0, 0, 1};
    int n;
    blk_valid = 1'b0; blk_w_log2 = 3'd0; blk_h_log2 = 3'd0;
    tx_w_log2 = 3'd0; tx_h_log2 = 3'd0; blk_mode = 7'd0;
    ref_done = 1'b0; pred_valid = 1'b0; recon_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    reset_dut();
    clear_log();

    // 16x16 with 8x8 transforms.
    issue(4, 4, 3, 3, 5);
    wait_idle(200, "blk16_done");
    chk("blk16_starts", n_start, 4);
    chk("blk16_done_cnt", n_done, 1);
    if (q_x.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("blk16_x", q_x[i], exp_x[i]);
        chk("blk16_y", q_y[i], exp_y[i]);
        chk("blk16_last", q_last[i], exp_l[i]);
      end
    end

    // 8x8 with oversize transform collapses to one sub-block.
    clear_log();
    issue(3, 3, 5, 4, 17);
    wait_idle(50, "blk8_done");
    chk("blk8_pred_w", int'(pred_w), 7);
    chk("blk8_pred_h", int'(pred_h), 7);
    chk("blk8_mode", int'(pred_mode), 17);
    chk("blk8_starts", n_start, 1);
    if (q_last.size() == 1) chk("blk8_last", q_last[0], 1);

    // 64x64 with 4x4 transforms.
    clear_log();
    issue(6, 6, 2, 2, 33);
    wait_idle(3000, "blk64_done");
    chk("blk64_starts", n_start, 256);
    chk("blk64_done_cnt", n_done, 1);
    if (q_x.size() > 0) begin
      chk("blk64_last_x", q_x[q_x.size()-1], 60);
      chk("blk64_last_y", q_y[q_y.size()-1], 60);
    end

    // Reconstruction back-pressure for 10 cycles.
    clear_log();
    p_rr = 0;
    issue(3, 3, 3, 3, 2);
    n = 0;
    while (m_st != 3 && n < 20) begin cycle(); n++; end
    for (int i = 0; i < 10; i++) cycle();
    chk("stall_pred_ready", int'(pred_ready), 0);
    chk("stall_tb_valid", int'(tb_valid), 1);
    chk("stall_done_cnt", n_done, 0);
    p_rr = 100;
    cycle();
    chk("stall_release_done", int'(blk_done), 1);
    wait_idle(20, "stall_idle");

    // Watchdog timeout.
    clear_log();
    p_pv = 0;
    issue(4, 4, 4, 4, 9);
    wait_idle(1200, "timeout_idle");
    chk("timeout_err", int'(err_timeout), 1);
    chk("timeout_done_cnt", n_done, 0);
    chk("timeout_blk_ready", int'(blk_ready), 1);
    p_pv = 100;
    issue(2, 2, 2, 2, 1);
    chk("timeout_err_clear", int'(err_timeout), 0);
    wait_idle(50, "after_timeout_idle");

    // Reset during the second sub-block.
    clear_log();
    issue(4, 4, 3, 3, 7);
    n = 0;
    while (n_start < 2 && n < 100) begin cycle(); n++; end
    cycle();
    reset_dut();
    chk("rst_ref_req", int'(ref_req), 0);
    chk("rst_pred_w", int'(pred_w), 0);
    clear_log();
    issue(4, 4, 3, 3, 7);
    wait_idle(200, "post_rst_done");
    chk("post_rst_starts", n_start, 4);
    if (q_x.size() > 0) begin
      chk("post_rst_x0", q_x[0], 0);
      chk("post_rst_y0", q_y[0], 0);
    end

    // Randomized traffic, including commands offered while busy.
    p_ref = 60; p_pv = 60; p_rr = 70;
    for (int i = 0; i < 5000; i++) begin
      blk_valid  = ($urandom_range(3) == 0);
      blk_w_log2 = 3'($urandom_range(7));
      blk_h_log2 = 3'($urandom_range(7));
      tx_w_log2  = 3'($urandom_range(7, 2));
      tx_h_log2  = 3'($urandom_range(7, 2));
      blk_mode   = 7'($urandom_range(127));
      cycle();
    end
    blk_valid = 1'b0;
    p_ref = 100; p_pv = 100; p_rr = 100;
    wait_idle(2000, "random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
